// File: rtl/dct_pkg.sv
// Shared types and default sizing for the DA DCT sequencer and its sample collector.
package dct_pkg;
  localparam int unsigned DCT_NSAMP = 8;
  localparam int unsigned DCT_BW    = 8;

  typedef enum logic [1:0] {IDLE, SHIFT, CAPT} dct_seq_state_t;
endpackage

// File: rtl/dct_sample_collector.sv
// Gathers NSAMP signed samples into one parallel block for the DA shifters.
// Refills while the datapath is busy; stalls upstream once a full block is waiting.
module dct_sample_collector
  import dct_pkg::*;
#(
  parameter int unsigned NSAMP = DCT_NSAMP,
  parameter int unsigned BW    = DCT_BW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  input  logic [BW-1:0]         i_data,
  input  logic                  i_clear,
  output logic                  o_ready,
  output logic                  o_full,
  output logic [NSAMP*BW-1:0]   o_blk
);
  localparam int unsigned SW        = (NSAMP > 1) ? $clog2(NSAMP) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(NSAMP - 1);

  logic [SW-1:0]        r_scnt;
  logic                 r_full;
  logic [NSAMP*BW-1:0]  r_blk;
  logic                 w_accept;

  assign o_ready  = !r_full && !reset;
  assign w_accept = i_valid && o_ready;
  assign o_full   = r_full;
  assign o_blk    = r_blk;

  // Accept and clear never coincide: accept needs !full, clear only fires when full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scnt <= '0;
      r_full <= 1'b0;
      r_blk  <= '0;
    end else begin
      if (i_clear) r_full <= 1'b0;
      if (w_accept) begin
        r_blk[32'(r_scnt)*BW +: BW] <= i_data;
        if (r_scnt == SLOT_LAST) begin
          r_scnt <= '0;
          r_full <= 1'b1;
        end else begin
          r_scnt <= r_scnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/dct_da_sequencer.sv
// Sequences the bit-serial DA DCT datapath: load, BW shift cycles (sign bit subtracts),
// then a capture strobe into a valid/ready result slot for the RLE stage.
module dct_da_sequencer
  import dct_pkg::*;
#(
  parameter int unsigned NSAMP = DCT_NSAMP,
  parameter int unsigned BW    = DCT_BW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [BW-1:0]           in_data,
  output logic                    in_ready,
  output logic [NSAMP*BW-1:0]     blk_data,
  output logic                    dp_load,
  output logic                    dp_acc_clr,
  output logic                    dp_shift,
  output logic                    dp_sub,
  output logic                    dp_rom_cs,
  output logic [$clog2(BW)-1:0]   bit_idx,
  output logic                    dp_capture,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);
  localparam int unsigned BIW = $clog2(BW);
  localparam logic [BIW-1:0] BIT_LAST = BIW'(BW - 1);

  dct_seq_state_t  r_state;
  logic [BIW-1:0]  r_bit;
  logic            r_out_valid;
  logic            w_full;

  dct_sample_collector #(.NSAMP(NSAMP), .BW(BW)) u_collector (
    .clk     (clk),
    .reset   (reset),
    .i_valid (in_valid),
    .i_data  (in_data),
    .i_clear (dp_load),
    .o_ready (in_ready),
    .o_full  (w_full),
    .o_blk   (blk_data)
  );

  // Strobes decode straight from state registers so reset forces them low at once.
  assign dp_load    = (r_state == IDLE) && w_full;
  assign dp_acc_clr = dp_load;
  assign dp_shift   = (r_state == SHIFT);
  assign dp_rom_cs  = dp_shift;
  assign dp_sub     = dp_shift && (r_bit == BIT_LAST);
  assign dp_capture = (r_state == CAPT) && (!r_out_valid || out_ready);
  assign busy       = (r_state != IDLE);
  assign bit_idx    = r_bit;
  assign out_valid  = r_out_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bit       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_full) begin
            r_bit   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (r_bit == BIT_LAST) begin
            r_bit   <= '0;
            r_state <= CAPT;
          end else begin
            r_bit <= r_bit + 1'b1;
          end
        end
        CAPT: begin
          // Stalled capture leaves every strobe low so the accumulator holds its value.
          if (dp_capture) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (dp_capture)     r_out_valid <= 1'b1;
      else if (out_ready) r_out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dct_da_sequencer.sv
// Self-checking bench for dct_da_sequencer: per-cycle reference model plus directed scenarios.
module tb_dct_da_sequencer;
  import dct_pkg::*;

  localparam int unsigned NS = DCT_NSAMP;
  localparam int unsigned BW = DCT_BW;
  localparam int unsigned BI = $clog2(BW);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic [BW-1:0]   in_data = '0;
  logic            in_ready;
  logic [NS*BW-1:0] blk_data;
  logic            dp_load, dp_acc_clr, dp_shift, dp_sub, dp_rom_cs, dp_capture;
  logic [BI-1:0]   bit_idx;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            busy;

  always #5 clk = ~clk;

  dct_da_sequencer #(.NSAMP(NS), .BW(BW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .blk_data   (blk_data),
    .dp_load    (dp_load),
    .dp_acc_clr (dp_acc_clr),
    .dp_shift   (dp_shift),
    .dp_sub     (dp_sub),
    .dp_rom_cs  (dp_rom_cs),
    .bit_idx    (bit_idx),
    .dp_capture (dp_capture),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int s_cyc   = 0;

  // Reference model: slot contents, fill count, pending-block flag,
  // phase since load (-1 idle, 0..BW-1 shifting, BW waiting to capture), result slot.
  logic [7:0] mb [NS];
  int         mcnt;
  bit         mfull;
  int         ph;
  bit         mov;

  logic s_in_ready, s_load, s_clr, s_shift, s_sub, s_cs, s_capt, s_ov, s_busy;
  logic [BI-1:0] s_bit;
  logic [63:0]   s_blk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model_blk();
    logic [63:0] b = '0;
    for (int i = 0; i < int'(NS); i++) b[i*8 +: 8] = mb[i];
    return b;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < int'(NS); i++) mb[i] = 8'h00;
    mcnt = 0;
    mfull = 1'b0;
    ph = -1;
    mov = 1'b0;
  endfunction

  // One clock: sample at negedge, compare with model, advance model, return at posedge+1.
  task automatic step();
    bit e_load, e_shift, e_capt;
    @(negedge clk);
    s_in_ready = in_ready; s_load = dp_load; s_clr = dp_acc_clr; s_shift = dp_shift;
    s_sub = dp_sub; s_cs = dp_rom_cs; s_capt = dp_capture; s_ov = out_valid;
    s_busy = busy; s_bit = bit_idx; s_blk = 64'(blk_data); s_cyc = cyc;
    e_load  = (ph < 0) && mfull;
    e_shift = (ph >= 0) && (ph < int'(BW));
    e_capt  = (ph == int'(BW)) && (!mov || out_ready);
    chk("in_ready",   64'(s_in_ready), 64'(!mfull));
    chk("dp_load",    64'(s_load),     64'(e_load));
    chk("dp_acc_clr", 64'(s_clr),      64'(e_load));
    chk("dp_shift",   64'(s_shift),    64'(e_shift));
    chk("dp_rom_cs",  64'(s_cs),       64'(e_shift));
    chk("dp_sub",     64'(s_sub),      64'(e_shift && ph == int'(BW) - 1));
    chk("dp_capture", 64'(s_capt),     64'(e_capt));
    chk("out_valid",  64'(s_ov),       64'(mov));
    chk("busy",       64'(s_busy),     64'(ph >= 0));
    chk("blk_data",   s_blk,           model_blk());
    if (e_shift) chk("bit_idx", 64'(s_bit), 64'(ph));
    if (in_valid && !mfull) begin
      mb[mcnt] = in_data;
      mcnt++;
      if (mcnt == int'(NS)) begin
        mcnt = 0;
        mfull = 1'b1;
      end
    end else if (e_load) begin
      mfull = 1'b0;
    end
    if (e_load)       ph = 0;
    else if (e_shift) ph++;
    else if (e_capt)  ph = -1;
    if (e_capt)         mov = 1'b1;
    else if (out_ready) mov = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asynchronous reset mid-cycle: every output must drop immediately.
  task automatic do_reset();
    #2 reset = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready",   64'(in_ready),   64'(0));
    chk("rst_dp_load",    64'(dp_load),    64'(0));
    chk("rst_dp_acc_clr", 64'(dp_acc_clr), 64'(0));
    chk("rst_dp_shift",   64'(dp_shift),   64'(0));
    chk("rst_dp_sub",     64'(dp_sub),     64'(0));
    chk("rst_dp_rom_cs",  64'(dp_rom_cs),  64'(0));
    chk("rst_dp_capture", 64'(dp_capture), 64'(0));
    chk("rst_out_valid",  64'(out_valid),  64'(0));
    chk("rst_busy",       64'(busy),       64'(0));
    chk("rst_bit_idx",    64'(bit_idx),    64'(0));
    chk("rst_blk_data",   64'(blk_data),   64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // Feed one block (in_valid 1 of every gap cycles) and check the full strobe timeline.
  task automatic run_block(input string tag, input logic [7:0] smp [NS], input int gap);
    int idx = 0, last = -1, ld = -1, cp = -1, nsh = 0, nsub = 0, subc = -1, early = 0, fsh = -1;
    logic [63:0] blk_ld = '0, exp_blk = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 200 && idx < int'(NS); k++) begin
      in_valid = ((k % gap) == 0);
      in_data  = smp[idx];
      step();
      if (s_load || s_shift || s_capt) early++;
      if (in_valid && s_in_ready) begin
        idx++;
        last = s_cyc;
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (s_load && ld < 0) begin
        ld = s_cyc;
        blk_ld = s_blk;
      end
      if (s_shift) begin
        nsh++;
        if (fsh < 0) fsh = s_cyc;
      end
      if (s_sub) begin
        nsub++;
        subc = s_cyc;
        chk({tag, "_sub_bit"}, 64'(s_bit), 64'(BW - 1));
      end
      if (s_capt) cp = s_cyc;
    end
    for (int i = 0; i < int'(NS); i++) exp_blk[i*8 +: 8] = smp[i];
    chk({tag, "_accepted"},    64'(idx),    64'(NS));
    chk({tag, "_early_strb"},  64'(early),  64'(0));
    chk({tag, "_load_cyc"},    64'(ld),     64'(last + 1));
    chk({tag, "_blk_at_load"}, blk_ld,      exp_blk);
    chk({tag, "_n_shift"},     64'(nsh),    64'(BW));
    chk({tag, "_first_shift"}, 64'(fsh),    64'(last + 2));
    chk({tag, "_n_sub"},       64'(nsub),   64'(1));
    chk({tag, "_sub_cyc"},     64'(subc),   64'(last + 1 + int'(BW)));
    chk({tag, "_capt_cyc"},    64'(cp),     64'(last + 2 + int'(BW)));
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       e_ir, e_load, e_shift, e_sub, e_capt, e_ov;
  } vec_t;

  vec_t       tbl [20];
  logic [7:0] smp [NS];
  int         acc [$];
  int         caps [$];
  int         got, nsh, ncap;

  initial begin
    model_reset();
    for (int i = 0; i < 20; i++) begin
      tbl[i] = '{iv: 1'b0, d: 8'h00, e_ir: 1'b1, e_load: 1'b0, e_shift: 1'b0,
                 e_sub: 1'b0, e_capt: 1'b0, e_ov: 1'b0};
      if (i < 8) begin
        tbl[i].iv = 1'b1;
        tbl[i].d  = 8'(i + 1);
      end
      if (i == 8) begin
        tbl[i].e_ir   = 1'b0;
        tbl[i].e_load = 1'b1;
      end
      if (i >= 9 && i <= 16) tbl[i].e_shift = 1'b1;
      if (i == 16) tbl[i].e_sub  = 1'b1;
      if (i == 17) tbl[i].e_capt = 1'b1;
      if (i == 18) tbl[i].e_ov   = 1'b1;
    end

    // Nominal block 1..8 through the hand-written vector table.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = tbl[i].iv;
      in_data  = tbl[i].d;
      step();
      chk("tbl_in_ready", 64'(s_in_ready), 64'(tbl[i].e_ir));
      chk("tbl_load",     64'(s_load),     64'(tbl[i].e_load));
      chk("tbl_shift",    64'(s_shift),    64'(tbl[i].e_shift));
      chk("tbl_sub",      64'(s_sub),      64'(tbl[i].e_sub));
      chk("tbl_capture",  64'(s_capt),     64'(tbl[i].e_capt));
      chk("tbl_out_valid",64'(s_ov),       64'(tbl[i].e_ov));
      if (tbl[i].e_load) chk("tbl_blk", s_blk, 64'h0807060504030201);
      if (tbl[i].e_sub)  chk("tbl_sub_bit", 64'(s_bit), 64'(BW - 1));
    end

    // Continuous stream of 4 blocks.
    do_reset();
    out_ready = 1'b1;
    acc.delete();
    caps.delete();
    for (int k = 0; k < 80; k++) begin
      in_valid = (acc.size() < 32);
      in_data  = 8'($urandom);
      step();
      if (in_valid && s_in_ready) acc.push_back(s_cyc);
      if (s_capt) caps.push_back(s_cyc);
    end
    in_valid = 1'b0;
    chk("cont_accepts", 64'(acc.size()), 64'(32));
    chk("cont_captures", 64'(caps.size()), 64'(4));
    if (caps.size() == 4)
      for (int k = 0; k < 3; k++) chk("cont_capt_spacing", 64'(caps[k+1] - caps[k]), 64'(10));
    if (acc.size() == 32)
      for (int k = 8; k < 24; k++) chk("cont_block_period", 64'(acc[k+8] - acc[k]), 64'(10));

    // Result slot stalled for 20 cycles after the first result.
    do_reset();
    out_ready = 1'b0;
    got = 0;
    for (int k = 0; k < 100 && got == 0; k++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      step();
      if (s_ov) got = 1;
    end
    chk("stall_first_result", 64'(got), 64'(1));
    nsh = 0;
    ncap = 0;
    for (int k = 0; k < 20; k++) begin
      in_data = 8'($urandom);
      step();
      if (k >= 10) begin
        if (s_shift) nsh++;
        if (s_capt)  ncap++;
      end
    end
    chk("stall_no_shift",   64'(nsh),        64'(0));
    chk("stall_no_capture", 64'(ncap),       64'(0));
    chk("stall_busy",       64'(s_busy),     64'(1));
    chk("stall_in_ready",   64'(s_in_ready), 64'(0));
    chk("stall_out_valid",  64'(s_ov),       64'(1));
    out_ready = 1'b1;
    step();
    chk("release_capture",   64'(s_capt), 64'(1));
    chk("release_out_valid", 64'(s_ov),   64'(1));
    step();
    chk("release_ov_kept",   64'(s_ov),   64'(1));
    in_valid = 1'b0;
    repeat (40) step();

    // Extreme sample values.
    do_reset();
    for (int i = 0; i < int'(NS); i++) smp[i] = (i % 2 == 0) ? 8'h80 : 8'h7F;
    run_block("extreme", smp, 1);

    // Reset during shift with a partial refill buffered.
    do_reset();
    for (int i = 0; i < int'(NS); i++) smp[i] = 8'($urandom);
    run_block("pre_rst", smp, 1);
    do_reset();
    got = 0;
    for (int k = 0; k < 30 && got == 0; k++) begin
      in_valid = (k < int'(NS));
      in_data  = 8'($urandom);
      step();
      if (s_load) got = 1;
    end
    chk("midrst_load_seen", 64'(got), 64'(1));
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("midrst_bit_idx",  64'(bit_idx), 64'(4));
    chk("midrst_buffered", 64'(mcnt),    64'(3));
    do_reset();
    for (int i = 0; i < int'(NS); i++) smp[i] = 8'($urandom);
    run_block("post_rst", smp, 1);

    // Gapped upstream, one valid in three cycles.
    for (int i = 0; i < int'(NS); i++) smp[i] = 8'($urandom);
    run_block("gapped", smp, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
